// File: rtl/alu_op_sequencer_if.sv
// Request, result, ALU-control and status signals between the format-I sequencer and its surroundings.
// master = host/ALU side, slave = sequencer.
interface alu_op_sequencer_if #(
  parameter int SIZE = 16
);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic            req_bw;
  logic [SIZE-1:0] req_src;
  logic [SIZE-1:0] req_dst;
  logic [3:0]      req_rpt;
  logic            sr_ld;
  logic [3:0]      sr_in;
  logic [SIZE-1:0] alu_src;
  logic [SIZE-1:0] alu_dst;
  logic            alu_bw;
  logic            alu_cin;
  logic [5:0]      alu_fs;
  logic [SIZE-1:0] alu_out;
  logic [3:0]      alu_cvnz;
  logic            res_valid;
  logic            res_ready;
  logic [SIZE-1:0] res_data;
  logic            res_wr;
  logic            res_err;
  logic [3:0]      sr_cvnz;

  modport master (
    output req_valid, req_op, req_bw, req_src, req_dst, req_rpt, sr_ld, sr_in,
    output alu_out, alu_cvnz, res_ready,
    input  req_ready, alu_src, alu_dst, alu_bw, alu_cin, alu_fs,
    input  res_valid, res_data, res_wr, res_err, sr_cvnz
  );

  modport slave (
    input  req_valid, req_op, req_bw, req_src, req_dst, req_rpt, sr_ld, sr_in,
    input  alu_out, alu_cvnz, res_ready,
    output req_ready, alu_src, alu_dst, alu_bw, alu_cin, alu_fs,
    output res_valid, res_data, res_wr, res_err, sr_cvnz
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences the ALU for MSP430 format-I instructions: latches operands, runs 1-16 passes
// chaining result and carry, owns the CVNZ status bits and hands back the final result.
module alu_op_sequencer #(
  parameter int SIZE = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] src_reg, dst_reg;
  logic [3:0]      op_reg, cnt;
  logic            bw_reg, err_reg;
  logic            accept, req_illegal, res_taken;
  logic [5:0]      dec_fs;
  logic            dec_cin, dec_wr, dec_flags;

  assign accept      = (state == IDLE) && bus.req_valid;
  assign req_illegal = (bus.req_op < 4'h4) || (bus.req_op == 4'hA);
  assign res_taken   = bus.res_valid && bus.res_ready;

  // Cin for ADDC/SUBC comes from the live C bit, so each repeat sees the previous pass's carry.
  always_comb begin
    dec_fs    = 6'b000000;
    dec_cin   = 1'b0;
    dec_wr    = 1'b0;
    dec_flags = 1'b0;
    case (op_reg)
      4'h4: begin dec_fs = 6'b010000; dec_wr = 1'b1; end
      4'h5: begin dec_fs = 6'b000000; dec_wr = 1'b1; dec_flags = 1'b1; end
      4'h6: begin dec_fs = 6'b000001; dec_cin = bus.sr_cvnz[3]; dec_wr = 1'b1; dec_flags = 1'b1; end
      4'h7: begin dec_fs = 6'b000011; dec_cin = bus.sr_cvnz[3]; dec_wr = 1'b1; dec_flags = 1'b1; end
      4'h8: begin dec_fs = 6'b000010; dec_cin = 1'b1; dec_wr = 1'b1; dec_flags = 1'b1; end
      4'h9: begin dec_fs = 6'b000010; dec_cin = 1'b1; dec_flags = 1'b1; end
      4'hB: begin dec_fs = 6'b010001; dec_flags = 1'b1; end
      4'hC: begin dec_fs = 6'b010010; dec_wr = 1'b1; end
      4'hD: begin dec_fs = 6'b010011; dec_wr = 1'b1; end
      4'hE: begin dec_fs = 6'b010100; dec_wr = 1'b1; dec_flags = 1'b1; end
      4'hF: begin dec_fs = 6'b010001; dec_wr = 1'b1; dec_flags = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = req_illegal ? DONE : EXEC;
      EXEC: if (cnt == 4'd0) state_nxt = DONE;
      DONE: if (res_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.alu_src   = '0;
    bus.alu_dst   = '0;
    bus.alu_bw    = 1'b0;
    bus.alu_cin   = 1'b0;
    bus.alu_fs    = 6'b000000;
    if (state == EXEC) begin
      bus.alu_src = src_reg;
      bus.alu_dst = dst_reg;
      bus.alu_bw  = bw_reg;
      bus.alu_cin = dec_cin;
      bus.alu_fs  = dec_fs;
    end
  end

  // An sr_ld coinciding with an accept lands before the first pass, so that pass uses the loaded C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg     <= '0;
      dst_reg     <= '0;
      op_reg      <= 4'h0;
      bw_reg      <= 1'b0;
      err_reg     <= 1'b0;
      cnt         <= 4'h0;
      bus.sr_cvnz <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sr_ld) bus.sr_cvnz <= bus.sr_in;
          if (accept) begin
            src_reg <= bus.req_src;
            dst_reg <= bus.req_dst;
            op_reg  <= bus.req_op;
            bw_reg  <= bus.req_bw;
            cnt     <= bus.req_rpt;
            err_reg <= req_illegal;
          end
        end
        EXEC: begin
          if (dec_wr)       dst_reg     <= bus.alu_out;
          if (dec_flags)    bus.sr_cvnz <= bus.alu_cvnz;
          if (cnt != 4'd0)  cnt         <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers fill one cycle after entering DONE and clear once the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_wr    <= 1'b0;
      bus.res_err   <= 1'b0;
    end else if ((state == DONE) && !res_taken) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= dst_reg;
      bus.res_wr    <= dec_wr && !err_reg;
      bus.res_err   <= err_reg;
    end else begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_wr    <= 1'b0;
      bus.res_err   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; a behavioural 16-bit ALU closes the loop on the alu_* side.
module tb_alu_op_sequencer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_op_sequencer_if #(.SIZE(16)) bus ();

  alu_op_sequencer #(.SIZE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] m_mask, m_a, m_b, m_r;
  logic [16:0] m_sum;
  logic        m_arith, m_msb_a, m_msb_b, m_msb_r, m_c, m_v;

  // Reference ALU: arithmetic computes dst + (src or ~src) + Cin, byte mode works on the low 8 bits.
  always_comb begin
    m_mask  = bus.alu_bw ? 16'h00FF : 16'hFFFF;
    m_a     = bus.alu_dst & m_mask;
    m_b     = (bus.alu_fs[1] ? ~bus.alu_src : bus.alu_src) & m_mask;
    m_sum   = {1'b0, m_a} + {1'b0, m_b} + {16'h0000, bus.alu_cin};
    m_arith = (bus.alu_fs[5:4] == 2'b00);
    case (bus.alu_fs)
      6'b010000: m_r = bus.alu_src;
      6'b010001: m_r = bus.alu_src & bus.alu_dst;
      6'b010010: m_r = ~bus.alu_src & bus.alu_dst;
      6'b010011: m_r = bus.alu_src | bus.alu_dst;
      6'b010100: m_r = bus.alu_src ^ bus.alu_dst;
      default:   m_r = m_sum[15:0];
    endcase
    m_r     = m_r & m_mask;
    m_msb_a = bus.alu_bw ? m_a[7] : m_a[15];
    m_msb_b = bus.alu_bw ? m_b[7] : m_b[15];
    m_msb_r = bus.alu_bw ? m_r[7] : m_r[15];
    m_c     = m_arith ? (bus.alu_bw ? m_sum[8] : m_sum[16]) : (m_r != 16'h0000);
    m_v     = m_arith && (m_msb_a == m_msb_b) && (m_msb_r != m_msb_a);
    bus.alu_out  = m_r;
    bus.alu_cvnz = {m_c, m_v, m_msb_r, (m_r == 16'h0000)};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic send(input logic [3:0] op, input logic bw, input logic [15:0] src,
                      input logic [15:0] dst, input logic [3:0] rpt);
    bus.req_op    = op;
    bus.req_bw    = bw;
    bus.req_src   = src;
    bus.req_dst   = dst;
    bus.req_rpt   = rpt;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int start, input int exp);
    int n = start;
    while ((bus.res_valid !== 1'b1) && (n < 40)) begin
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask

  task automatic take_result(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check(tag, {bus.req_ready, bus.res_valid}, 2'b10);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'h0;
    bus.req_bw    = 1'b0;
    bus.req_src   = 16'h0000;
    bus.req_dst   = 16'h0000;
    bus.req_rpt   = 4'h0;
    bus.sr_ld     = 1'b0;
    bus.sr_in     = 4'h0;
    bus.res_ready = 1'b0;

    #12;
    check("rst_ready_valid", {bus.req_ready, bus.res_valid, bus.res_wr, bus.res_err}, 4'b1000);
    check("rst_sr", bus.sr_cvnz, 4'h0);
    check("rst_alu", {bus.alu_fs, bus.alu_cin, bus.alu_src}, 23'h0);
    check("rst_res_data", bus.res_data, 16'h0000);
    rst_n = 1'b1;
    tick();

    $display("[TB] ADD.W 7FFF+0001");
    send(4'h5, 1'b0, 16'h7FFF, 16'h0001, 4'h0);
    check("add_exec_ctrl", {bus.req_ready, bus.alu_fs, bus.alu_cin}, {1'b0, 6'b000000, 1'b0});
    check("add_exec_ops", {bus.alu_src, bus.alu_dst}, {16'h7FFF, 16'h0001});
    wait_valid("add_latency", 0, 2);
    check("add_res", {bus.res_wr, bus.res_err, bus.res_data}, {1'b1, 1'b0, 16'h8000});
    check("add_sr", bus.sr_cvnz, 4'b0110);
    take_result("add_release");

    $display("[TB] ADDC.W rpt=2 with sr_ld on accept");
    bus.sr_ld = 1'b1;
    bus.sr_in = 4'b1000;
    send(4'h6, 1'b0, 16'h0000, 16'hFFFF, 4'h2);
    bus.sr_ld = 1'b0;
    check("addc_p1_ctrl", {bus.alu_fs, bus.alu_cin, bus.alu_dst}, {6'b000001, 1'b1, 16'hFFFF});
    tick();
    check("addc_p2_ctrl", {bus.alu_cin, bus.alu_dst}, {1'b1, 16'h0000});
    check("addc_p1_sr", bus.sr_cvnz, 4'b1001);
    tick();
    check("addc_p3_ctrl", {bus.alu_cin, bus.alu_dst}, {1'b0, 16'h0001});
    wait_valid("addc_latency", 2, 4);
    check("addc_res", {bus.res_wr, bus.res_data}, {1'b1, 16'h0001});
    check("addc_sr", bus.sr_cvnz, 4'b0000);
    take_result("addc_release");

    $display("[TB] CMP.W 0005,0005");
    send(4'h9, 1'b0, 16'h0005, 16'h0005, 4'h0);
    check("cmp_exec_ctrl", {bus.alu_fs, bus.alu_cin}, {6'b000010, 1'b1});
    wait_valid("cmp_latency", 0, 2);
    check("cmp_res", {bus.res_wr, bus.res_data}, {1'b0, 16'h0005});
    check("cmp_sr", bus.sr_cvnz, 4'b1001);
    take_result("cmp_release");

    $display("[TB] BIS.B with SR=1111, sr_ld outside IDLE");
    bus.sr_ld = 1'b1;
    bus.sr_in = 4'b1111;
    tick();
    bus.sr_ld = 1'b0;
    check("sr_load_idle", bus.sr_cvnz, 4'b1111);
    send(4'hD, 1'b1, 16'h00F0, 16'h000F, 4'h0);
    check("bis_exec_ctrl", {bus.alu_bw, bus.alu_fs}, {1'b1, 6'b010011});
    bus.sr_ld = 1'b1;
    bus.sr_in = 4'b0000;
    wait_valid("bis_latency", 0, 2);
    bus.sr_ld = 1'b0;
    check("bis_res", {bus.res_wr, bus.res_data}, {1'b1, 16'h00FF});
    check("bis_sr", bus.sr_cvnz, 4'b1111);
    take_result("bis_release");

    $display("[TB] illegal opcode A, held result, pending request");
    send(4'hA, 1'b0, 16'h1234, 16'hABCD, 4'h3);
    check("ill_no_exec", {bus.alu_fs, bus.alu_src}, 22'h0);
    wait_valid("ill_latency", 0, 1);
    bus.req_op    = 4'h4;
    bus.req_bw    = 1'b0;
    bus.req_src   = 16'h5A5A;
    bus.req_dst   = 16'h0000;
    bus.req_rpt   = 4'h0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ill_hold", {bus.res_valid, bus.res_err, bus.res_wr, bus.req_ready, bus.res_data},
            {4'b1100, 16'hABCD});
      tick();
    end
    check("ill_sr", bus.sr_cvnz, 4'b1111);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("ill_release", {bus.req_ready, bus.res_valid}, 2'b10);
    tick();
    bus.req_valid = 1'b0;
    check("mov_exec_ctrl", {bus.alu_fs, bus.alu_src}, {6'b010000, 16'h5A5A});
    wait_valid("mov_latency", 0, 2);
    check("mov_res", {bus.res_wr, bus.res_err, bus.res_data}, {1'b1, 1'b0, 16'h5A5A});
    check("mov_sr", bus.sr_cvnz, 4'b1111);
    take_result("mov_release");

    $display("[TB] reset during pass 2 of ADD rpt=3");
    send(4'h5, 1'b0, 16'h0001, 16'h0001, 4'h3);
    tick();
    check("abort_pre", bus.alu_dst, 16'h0002);
    rst_n = 1'b0;
    #1;
    check("abort_state", {bus.req_ready, bus.res_valid}, 2'b10);
    check("abort_sr", bus.sr_cvnz, 4'b0000);
    check("abort_alu", {bus.alu_src, bus.alu_dst}, 32'h0);
    #1;
    rst_n = 1'b1;
    send(4'h8, 1'b0, 16'h0003, 16'h000A, 4'h0);
    check("sub_exec_ctrl", {bus.alu_fs, bus.alu_cin}, {6'b000010, 1'b1});
    wait_valid("sub_latency", 0, 2);
    check("sub_res", {bus.res_wr, bus.res_data}, {1'b1, 16'h0007});
    check("sub_sr", bus.sr_cvnz, 4'b1000);
    take_result("sub_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Controller that sequences the 16-bit ALU for MSP430 format-I two-operand instructions.
- Accepts one operation per request handshake and latches its operands.
- Drives the ALU control inputs (FS, BW, Cin) and repeats the operation 1-16 times, chaining result and carry between passes.
- Owns the CVNZ status bits and presents the final result with a write-back qualifier to the register-file side.

Parameters:
SIZE, 16, datapath width; BW=1 selects the low SIZE/2 bits inside the ALU.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  operation request
req_ready  out  1  sequencer can accept (high only in IDLE)
req_op  in  4  format-I opcode, 4h4..4hF
req_bw  in  1  byte (1) / word (0)
req_src  in  SIZE  source operand
req_dst  in  SIZE  destination operand
req_rpt  in  4  extra passes; executes req_rpt+1 times
sr_ld  in  1  load status bits from sr_in (honoured in IDLE only)
sr_in  in  4  CVNZ load value
alu_src  out  SIZE  ALU SRC
alu_dst  out  SIZE  ALU DST
alu_bw  out  1  ALU BW
alu_cin  out  1  ALU Cin
alu_fs  out  6  ALU FS
alu_out  in  SIZE  ALU_OUT
alu_cvnz  in  4  ALU CVNZ_alu
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_data  out  SIZE  final result
res_wr  out  1  res_data must be written to destination
res_err  out  1  opcode not supported
sr_cvnz  out  4  status register {C,V,N,Z}

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - All latched operands, repeat count, sr_cvnz, res_* and alu_* outputs = 0.
  - req_ready follows state, so it is 1 in IDLE; no accept occurs while rst_n is low.
  - Reset mid-operation aborts the operation with no SR update.
- States:
  - IDLE -> EXEC on req_valid & req_ready. Latch src, dst, op, bw, and cnt=req_rpt.
  - IDLE -> DONE on accept of illegal opcode 4hA (DADD) or 4h0-4h3. res_err=1, res_wr=0, res_data=latched dst; SR unchanged.
  - EXEC: ALU inputs driven from latched registers (alu_* are 0 outside EXEC). One pass per cycle. At the clock edge:
    - dst_reg <= alu_out for writing ops; unchanged for CMP and BIT.
    - sr_cvnz <= alu_cvnz for flag ops.
    - If cnt==0 go to DONE, else cnt--.
  - DONE: res_valid=1; res_data=dst_reg. Hold all res_* until res_ready, then go to IDLE.
- FS / Cin / write / flags per opcode:
  - MOV: FS=6b010000, Cin 0, write, no flags.
  - ADD: FS=6b000000, Cin 0, write, flags.
  - ADDC: FS=6b000001, Cin=sr C, write, flags.
  - SUBC: FS=6b000011, Cin=sr C, write, flags.
  - SUB: FS=6b000010, Cin 1, write, flags.
  - CMP: FS=6b000010, Cin 1, no write, flags.
  - BIT: FS=6b010001, Cin 0, no write, flags.
  - BIC: FS=6b010010, Cin 0, write, no flags.
  - BIS: FS=6b010011, Cin 0, write, no flags.
  - XOR: FS=6b010100, Cin 0, write, flags.
  - AND: FS=6b010001, Cin 0, write, flags.
- Carry chaining: ADDC/SUBC Cin is taken from the current sr_cvnz[3], so each repeat sees the carry written by the previous pass.
- Width: the sequencer never masks data. res_data carries full alu_out; byte truncation and flags are the ALU's responsibility.
- Latency: accept at edge 0; passes at edges 1..N+1; res_valid high from edge N+2 (N=req_rpt). Minimum 2 cycles accept-to-result.
- sr_ld:
  - In IDLE: sr_cvnz <= sr_in.
  - In IDLE together with an accept: the load applies and the first pass uses the loaded C.
  - Outside IDLE: ignored.
- Simultaneous events:
  - res_ready with res_valid low: ignored.
  - req_valid outside IDLE: not accepted and request not consumed.
  - res_wr=0 for CMP, BIT and illegal ops.

Test Plan:
- SR=0; ADD.W src=7FFF dst=0001 rpt=0 -> one EXEC cycle, alu_fs=00, alu_cin=0; res_data=8000, res_wr=1, sr_cvnz=0110, res_valid 2 cycles after accept.
- sr_ld=1 with sr_in=1000 in IDLE; ADDC.W src=0000 dst=FFFF rpt=2 -> pass 1 gives 0000 with C=1; passes 2 and 3 give 0001 then 0001. Final res_data=0001, sr_cvnz C=0, res_valid at cycle 4.
- CMP.W src=0005 dst=0005 -> alu_cin=1, res_wr=0, res_data=0005, sr_cvnz=1001.
- BIS.B src=00F0 dst=000F with sr_cvnz=1111 -> res_data=00FF, res_wr=1, sr_cvnz stays 1111.
- req_op=A -> no EXEC cycle, res_err=1, res_wr=0 next cycle. Hold res_ready=0 for 3 cycles -> res_* stable and req_ready=0 throughout.
- Assert rst_n=0 during pass 2 of rpt=3 ADD -> immediately IDLE, req_ready=1, res_valid=0, sr_cvnz=0000. A following request runs normally.
